mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n, both inputs.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  1  CPU access request; sampled only when ready=1.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-justified.
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done: access rejected.
REQ-013 SHALL have port rdata  output  32  load result, held until the next done.
REQ-014 SHALL have port data_addr  output  32  word index to data memory.
REQ-015 SHALL have port wr_data  output  32  word written to data memory.
REQ-016 SHALL have port wmem  output  1  data memory write enable.
REQ-017 SHALL have port dout_mem  input  32  combinational read word from data memory.

Function
REQ-018 SHALL drive data_addr = {26'b0, addr_q[7:2]}, where addr_q is the address latched at accept, for 64-word memory.
REQ-019 SHALL accept a request on the rising edge where state=IDLE and req=1, latching we, size, sign_ext, addr and wdata.
REQ-020 SHALL reject an access at accept when size=11, when addr[31:8]!=0, when a half access has addr[0]=1, or when a word access has addr[1:0]!=0; the sequence is then IDLE->ERR->IDLE, with done=1 and err=1 during ERR, no wmem, and rdata unchanged.
REQ-021 SHALL run loads as IDLE->RD->DONE; at the RD->DONE edge, rdata captures the addressed byte lane or half lane (lane=addr_q[1:0], little-endian) of dout_mem, extended per sign_ext; word loads capture dout_mem unchanged.
REQ-022 SHALL run word stores as IDLE->WR->DONE, with wmem=1 and wr_data=wdata_q only during WR.
REQ-023 SHALL run byte and half stores as IDLE->RD->WR->DONE, registering dout_mem in RD and, in WR, writing that word with only the addressed lane replaced by wdata_q[7:0] or wdata_q[15:0].
REQ-024 SHALL assert done=1 (err=0) for exactly the DONE cycle, and SHALL then return to IDLE.
REQ-025 SHALL decode wmem from the registered state only; wmem SHALL be high for exactly one cycle per successful store and never on loads or errors.
REQ-026 SHALL ignore req while ready=0, with no queuing.
REQ-027 SHALL allow back-to-back access: a req at the edge leaving DONE is not accepted; acceptance occurs at the first IDLE edge.
REQ-028 SHALL give load latency: done in the 2nd cycle after the accept edge; word store done in the 2nd cycle; sub-word store done in the 3rd cycle.
REQ-029 SHALL drive wr_data=0 outside WR.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, ready=1, done=0, err=0, rdata=0, wmem=0, wr_data=0, and all latched request registers to 0.
REQ-031 SHALL abort an in-flight access when reset asserts mid-operation: wmem drops asynchronously, no partial write completes, and no done is issued after release.

Structure
REQ-032 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state encodings (IDLE, RD, WR, DONE, ERR) and MEM_DEPTH=64 in the shared package.
REQ-033 SHALL implement lane extract/extend and lane merge in one combinational sub-module, mem_lane_align; the FSM and registers stay in mem_access_ctrl.

Verification
REQ-034 SHALL cover: reset, then a load of byte addr 0x00, sign_ext=1, with memory word 0 = 0x800000FF -> rdata=0xFFFFFFFF, done in the 2nd cycle after accept.
REQ-035 SHALL cover: a load of half addr 0x02, sign_ext=0, with word 0 = 0x800000FF -> rdata=0x00008000; byte addr 0x03, signed -> 0xFFFFFF80.
REQ-036 SHALL cover: a store of byte 0xAB at addr 0x05, with word 1 = 0x800000FF -> a single wmem pulse writing 0x8000ABFF to data_addr 1; a subsequent word load -> 0x8000ABFF.
REQ-037 SHALL cover: a word load at addr 0x06, and separately addr 0x100 -> done=1 with err=1, no wmem, rdata unchanged.
REQ-038 SHALL cover: rst_n pulsed low during WR of a half store -> wmem falls immediately, the memory word is unchanged, and ready=1 after release.
REQ-039 SHALL cover: req held high continuously across 3 word stores -> exactly 3 wmem pulses and 3 done pulses, each accept occurring in IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings and access legality check for mem_access_ctrl
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MEM_DEPTH = 64;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    // An access is rejected for the reserved size, an address past the data
    // memory, or a half/word that is not naturally aligned.
    function automatic logic access_bad(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11)
            bad = 1'b1;
        if (addr[31:MEM_AW+2] != '0)
            bad = 1'b1;
        if ((size == SZ_HALF) && addr[0])
            bad = 1'b1;
        if ((size == SZ_WORD) && (addr[1:0] != 2'b00))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    input  logic [31:0] base_word,
    output logic [31:0] ld_data,
    output logic [31:0] wr_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] ins;

    // Shift the addressed lane down for loads, and build a lane mask to splice store data in.
    always_comb begin
        shamt   = {lane, 3'b000};
        shifted = rd_word >> shamt;
        ld_data = rd_word;
        mask    = 32'hFFFF_FFFF;
        ins     = st_data;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                mask    = 32'h0000_00FF << shamt;
                ins     = {24'b0, st_data[7:0]} << shamt;
            end
            SZ_HALF: begin
                ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                mask    = 32'h0000_FFFF << shamt;
                ins     = {16'b0, st_data[15:0]} << shamt;
            end
            default: ;
        endcase
        wr_word = (base_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU load/store sequencer for a 64-word data memory
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] data_addr,
    output logic [31:0] wr_data,
    output logic        wmem,
    input  logic [31:0] dout_mem
);

    state_t              state_q;
    state_t              state_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         base_q;
    logic [31:0]         ld_data;
    logic [31:0]         merged;
    logic                accept;

    assign accept    = (state_q == IDLE) && req;
    assign data_addr = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};

    mem_lane_align u_align (
        .size      (size_q),
        .lane      (addr_q[1:0]),
        .sign_ext  (sext_q),
        .rd_word   (dout_mem),
        .st_data   (wdata_q),
        .base_word (base_q),
        .ld_data   (ld_data),
        .wr_word   (merged)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: sub-word stores read the old word first, word stores write directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (access_bad(size, addr))
                        state_d = ERR;
                    else if (we && (size == SZ_WORD))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the request at accept so the CPU side may change during the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
        end else if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr[MEM_AW+1:0];
            wdata_q <= wdata;
        end
    end

    // In RD, loads capture the aligned result and sub-word stores keep the old word for merging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= 32'b0;
            base_q <= 32'b0;
        end else if (state_q == RD) begin
            if (we_q)
                base_q <= dout_mem;
            else
                rdata <= ld_data;
        end
    end

    // Outputs decoded purely from the registered state.
    always_comb begin
        ready   = (state_q == IDLE);
        done    = (state_q == DONE) || (state_q == ERR);
        err     = (state_q == ERR);
        wmem    = (state_q == WR);
        wr_data = (state_q == WR) ? merged : 32'b0;
    end

endmodule
